// File: rtl/fetch_stage.sv
// Instruction fetch: 2-entry in-order {pc,instr} buffer fed by a pipelined imem; request-to-output latency 2, 1 instr/cycle sustained.
// StallF holds the head; imem_req is withheld once buffered + in-flight would exceed 2. FETCH_PERF_CNT_EN adds perf counters.

module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubble
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] buf_pc_q    [2];
  logic [DATA_WIDTH-1:0] buf_instr_q [2];
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            outst_q, outst_d;
  logic [2:0]            drop_q, drop_d;

  // Addresses of accepted, still-expected requests, oldest at pend_rd_q.
  logic [DATA_WIDTH-1:0] pend_pc_q [2];
  logic                  pend_wr_q, pend_wr_d;
  logic                  pend_rd_q, pend_rd_d;

  logic buf_vld;
  logic pop;
  logic push;
  logic accept;
  logic rsp_any;
  logic rsp_drop;
  logic rsp_keep;
  logic issue_ok;
  logic tail;
  logic tgt_unused;

  assign tgt_unused = ^PCTargetE[1:0];

  assign buf_vld  = (occ_q != 2'd0);
  assign rsp_any  = imem_rvalid && ((outst_q != 2'd0) || (drop_q != 3'd0));
  assign rsp_drop = imem_rvalid && (drop_q != 3'd0);
  assign rsp_keep = imem_rvalid && (drop_q == 3'd0) && (outst_q != 2'd0);
  assign pop      = buf_vld && !StallF && !PCSrcE;
  assign push     = rsp_keep && !PCSrcE && !rst;
  // A full buffer has its tail on the head slot, which is only written while it is being popped.
  assign tail     = head_q ^ occ_q[0];

  assign issue_ok  = ({1'b0, occ_q} + {1'b0, outst_q}) < (3'd2 + {2'b00, pop});
  assign imem_req  = !rst && !PCSrcE && issue_ok;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q ^ pop;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    outst_d    = outst_q + {1'b0, accept} - {1'b0, rsp_keep};
    drop_d     = drop_q - {2'b00, rsp_drop};
    pend_wr_d  = pend_wr_q ^ accept;
    pend_rd_d  = pend_rd_q ^ rsp_keep;
    if (accept) begin
      fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    end
    if (PCSrcE) begin
      // Everything in flight, including a response landing this cycle, belongs to the wrong path.
      fetch_pc_d = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
      head_d     = 1'b0;
      occ_d      = 2'd0;
      outst_d    = 2'd0;
      drop_d     = drop_q + {1'b0, outst_q} - {2'b00, rsp_any};
      pend_rd_d  = pend_wr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      outst_q    <= 2'd0;
      drop_q     <= 3'd0;
      pend_wr_q  <= 1'b0;
      pend_rd_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[tail]    <= pend_pc_q[pend_rd_q];
      buf_instr_q[tail] <= imem_rdata;
    end
    if (accept) begin
      pend_pc_q[pend_wr_q] <= fetch_pc_q;
    end
  end

  assign fetch_valid = !rst && buf_vld;
  assign instr       = fetch_valid ? buf_instr_q[head_q] : NOP;
  assign PCF         = fetch_valid ? buf_pc_q[head_q] : '0;
  assign PCPlus4F    = fetch_valid ? buf_pc_q[head_q] + DATA_WIDTH'(4) : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_bubble_q  <= 32'd0;
    end else begin
      if (pop) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (!fetch_valid && !StallF) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: pipelined imem model, expected-pop scoreboard plus per-cycle spot checks.
// Covers reset, streaming, stall, redirect drop, imem backpressure, mid-flight reset and (optionally) perf counters.

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubble (perf_bubble)
`endif
  );

  localparam logic [31:0] DOFS = 32'h1000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  exp_t  sbq[$];
  mreq_t memq[$];
  exp_t  mon_e;

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mem_lat = 1;
  logic mem_ready = 1'b1;
  bit   stale_pending = 1'b0;
  bit   rv_stale;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_instr;
  logic [31:0] s_pcf;
  logic [31:0] s_pc4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_pc(input logic [31:0] pc);
    sbq.push_back('{pc: pc, ins: pc + DOFS});
  endtask

  // One clock cycle: inputs change at the falling edge, memory and outputs are sampled 1ns later.
  task automatic step(input logic r, input logic st, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst        = r;
    StallF     = st;
    PCSrcE     = br;
    PCTargetE  = tgt;
    imem_ready = mem_ready;
    rv_stale   = 1'b0;
    if (stale_pending) begin
      imem_rvalid   = 1'b1;
      imem_rdata    = 32'hDEAD_BEEF;
      rv_stale      = 1'b1;
      stale_pending = 1'b0;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memq[0].addr + DOFS;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0BAD_0BAD;
    end
    #1;
    if (imem_rvalid && !rv_stale) void'(memq.pop_front());
    if (imem_req && imem_ready) memq.push_back('{addr: imem_addr, due: cyc + mem_lat});
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = fetch_valid;
    s_instr = instr;
    s_pcf   = PCF;
    s_pc4   = PCPlus4F;
    cyc++;
  endtask

  task automatic reset_dut(input bit stale);
    memq.delete();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("rst_req", {31'd0, s_req}, 32'd0);
      check("rst_valid", {31'd0, s_valid}, 32'd0);
      check("rst_instr", s_instr, NOP);
    end
    check("rst_pcf", s_pcf, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'd0);
    check("rst_perf_bubble", perf_bubble, 32'd0);
`endif
    stale_pending = stale;
  endtask

  task automatic sb_done(input string name);
    #2;
    check(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Every instruction the DUT hands to decode must be the next one expected.
  always @(negedge clk) begin
    #2;
    if (fetch_valid && !StallF && !PCSrcE) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_pop: got pc=%h instr=%h with nothing expected", PCF, instr);
      end else begin
        mon_e = sbq.pop_front();
        if (PCF !== mon_e.pc || instr !== mon_e.ins || PCPlus4F !== mon_e.pc + 32'd4) begin
          n_fail++;
          $display("FAIL sb_pop: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                   PCF, instr, PCPlus4F, mon_e.pc, mon_e.ins, mon_e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Streaming from reset, zero-wait memory.
    mem_lat = 1; mem_ready = 1'b1;
    reset_dut(1'b0);
    for (int p = 0; p <= 20; p += 4) exp_pc(32'(p));
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 0) begin
        check("first_req", {31'd0, s_req}, 32'd1);
        check("first_addr", s_addr, 32'h0);
      end
      if (c == 1) check("lat2_not_yet", {31'd0, s_valid}, 32'd0);
      if (c >= 2 && c <= 5) begin
        check("stream_valid", {31'd0, s_valid}, 32'd1);
        check("stream_pcf", s_pcf, 32'(4 * (c - 2)));
      end
    end
    sb_done("stream_drain");

    // Stall for 3 cycles while PC 8 is at the head.
    reset_dut(1'b0);
    for (int p = 0; p <= 20; p += 4) exp_pc(32'(p));
    for (int c = 0; c < 11; c++) begin
      step(1'b0, (c >= 4 && c <= 6), 1'b0, 32'h0);
      if (c >= 4 && c <= 6) begin
        check("stall_pcf", s_pcf, 32'h8);
        check("stall_instr", s_instr, 32'h8 + DOFS);
        check("stall_req_off", {31'd0, s_req}, 32'd0);
      end
      if (c == 7) begin
        check("unstall_req", {31'd0, s_req}, 32'd1);
        check("unstall_addr", s_addr, 32'h10);
      end
      if (c == 8) check("unstall_pcf", s_pcf, 32'hC);
    end
    sb_done("stall_drain");

    // Redirect to 0x103 with two requests in flight on a 2-cycle memory.
    mem_lat = 2;
    reset_dut(1'b0);
    exp_pc(32'h0); exp_pc(32'h4); exp_pc(32'h100); exp_pc(32'h104); exp_pc(32'h108);
    for (int c = 0; c < 13; c++) begin
      step(1'b0, 1'b0, (c == 5), (c == 5) ? 32'h103 : 32'h0);
      if (c == 5) check("redir_no_req", {31'd0, s_req}, 32'd0);
      if (c == 6) begin
        check("redir_req", {31'd0, s_req}, 32'd1);
        check("redir_addr", s_addr, 32'h100);
      end
      if (c >= 6 && c <= 8) check("redir_dropped", {31'd0, s_valid}, 32'd0);
      if (c == 9) check("redir_first_pcf", s_pcf, 32'h100);
    end
    sb_done("redir_drain");

    // imem_ready low for 4 cycles drains the buffer.
    mem_lat = 1;
    reset_dut(1'b0);
    for (int p = 0; p <= 20; p += 4) exp_pc(32'(p));
    for (int c = 0; c < 12; c++) begin
      mem_ready = !(c >= 4 && c <= 7);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 5) check("bp_addr_held", s_addr, 32'h10);
      if (c >= 6 && c <= 9) begin
        check("bp_valid", {31'd0, s_valid}, 32'd0);
        check("bp_instr_nop", s_instr, NOP);
        check("bp_pcf", s_pcf, 32'h0);
        check("bp_pc4", s_pc4, 32'h0);
      end
      if (c == 8) begin
        check("bp_resume_req", {31'd0, s_req}, 32'd1);
        check("bp_resume_addr", s_addr, 32'h10);
      end
      if (c == 10) check("bp_resume_pcf", s_pcf, 32'h10);
    end
    mem_ready = 1'b1;
    sb_done("bp_drain");

    // Reset with two in flight, then a stale response right after release.
    mem_lat = 2;
    reset_dut(1'b0);
    exp_pc(32'h0); exp_pc(32'h4);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, 32'h0);
    sb_done("pre_rst_drain");
    mem_lat = 1;
    reset_dut(1'b1);
    exp_pc(32'h0); exp_pc(32'h4);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 0) begin
        check("rst_rel_req", {31'd0, s_req}, 32'd1);
        check("rst_rel_addr", s_addr, 32'h0);
      end
      if (c == 1) check("stale_ignored", {31'd0, s_valid}, 32'd0);
      if (c == 2) begin
        check("rst_rel_pcf", s_pcf, 32'h0);
        check("rst_rel_instr", s_instr, DOFS);
      end
    end
    sb_done("rst_rel_drain");

`ifdef FETCH_PERF_CNT_EN
    // Three unstalled empty cycles (one stalled empty cycle excluded), then 10 pops.
    mem_lat = 1;
    reset_dut(1'b0);
    for (int p = 0; p <= 40; p += 4) exp_pc(32'(p));
    for (int c = 0; c < 15; c++) begin
      mem_ready = (c >= 2);
      step(1'b0, (c == 1), 1'b0, 32'h0);
      if (c == 14) begin
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_bubble", perf_bubble, 32'd3);
      end
    end
    mem_ready = 1'b1;
    sb_done("perf_drain");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
